// File: rtl/dmem_arbiter.sv
`timescale 1ns/1ps
// Purpose: arbitrates the CPU load/store path and the debug/loader port onto one single-port data memory.
// Latency: arbitration -> ISSUE next cycle -> rvalid MEM_LAT+2 cycles after arbitration; one access in flight.
// Backpressure: a requester holds req until its gnt; CPU wins by default, DBG wins after STARVE_MAX lost rounds.
module dmem_arbiter #(
  parameter int ADDR_W     = 64,
  parameter int DATA_W     = 64,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

  localparam logic [3:0] LAT_INIT   = 4'(MEM_LAT - 1);
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  state_t            state_q, state_d;
  logic [3:0]        starve_q, starve_d;
  logic [3:0]        lat_q, lat_d;
  logic              own_dbg_q, own_dbg_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              cpu_rvalid_q, cpu_rvalid_d;
  logic              dbg_rvalid_q, dbg_rvalid_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0] dbg_rdata_q, dbg_rdata_d;
  logic              dbg_win;

  // DBG takes the slot when the CPU is quiet or DBG has been starved long enough
  assign dbg_win = dbg_req & (~cpu_req | (starve_q == STARVE_LIM));

  // Next-state: arbitration in IDLE, one ISSUE cycle, MEM_LAT WAIT cycles with read capture on the last
  always_comb begin
    state_d      = state_q;
    starve_d     = starve_q;
    lat_d        = lat_q;
    own_dbg_d    = own_dbg_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    cpu_rvalid_d = 1'b0;
    dbg_rvalid_d = 1'b0;
    cpu_rdata_d  = cpu_rdata_q;
    dbg_rdata_d  = dbg_rdata_q;
    case (state_q)
      S_IDLE: begin
        if (dbg_win) begin
          own_dbg_d = 1'b1;
          we_d      = dbg_we;
          addr_d    = dbg_addr;
          wdata_d   = dbg_wdata;
          starve_d  = '0;
          state_d   = S_ISSUE;
        end else if (cpu_req) begin
          own_dbg_d = 1'b0;
          we_d      = cpu_we;
          addr_d    = cpu_addr;
          wdata_d   = cpu_wdata;
          // DBG lost this round: count it, saturating at the limit
          if (dbg_req && (starve_q != STARVE_LIM)) starve_d = starve_q + 4'd1;
          state_d   = S_ISSUE;
        end
      end
      S_ISSUE: begin
        lat_d   = LAT_INIT;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (lat_q == 4'd0) begin
          if (!we_q) begin
            if (own_dbg_q) begin
              dbg_rdata_d  = mem_rdata;
              dbg_rvalid_d = 1'b1;
            end else begin
              cpu_rdata_d  = mem_rdata;
              cpu_rvalid_d = 1'b1;
            end
          end
          state_d = S_IDLE;
        end else begin
          lat_d = lat_q - 4'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any in-flight access
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      starve_q     <= '0;
      lat_q        <= '0;
      own_dbg_q    <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      cpu_rvalid_q <= 1'b0;
      dbg_rvalid_q <= 1'b0;
      cpu_rdata_q  <= '0;
      dbg_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      starve_q     <= starve_d;
      lat_q        <= lat_d;
      own_dbg_q    <= own_dbg_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      cpu_rvalid_q <= cpu_rvalid_d;
      dbg_rvalid_q <= dbg_rvalid_d;
      cpu_rdata_q  <= cpu_rdata_d;
      dbg_rdata_q  <= dbg_rdata_d;
    end
  end

  // Address/data come straight from the access registers so they hold between accesses
  assign mem_en     = (state_q == S_ISSUE);
  assign mem_we     = mem_en & we_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign cpu_gnt    = mem_en & ~own_dbg_q;
  assign dbg_gnt    = mem_en & own_dbg_q;
  assign cpu_rvalid = cpu_rvalid_q;
  assign dbg_rvalid = dbg_rvalid_q;
  assign cpu_rdata  = cpu_rdata_q;
  assign dbg_rdata  = dbg_rdata_q;
  // A store releases the CPU at grant; a load releases it when the data returns
  assign cpu_stall  = cpu_req & ~(cpu_rvalid | (cpu_gnt & cpu_we));

endmodule

// File: tb/tb_dmem_arbiter.sv
`timescale 1ns/1ps
// Bench for dmem_arbiter: directed vectors with a scoreboard on memory accesses and read returns.
// Main instance uses MEM_LAT=1; a second instance with MEM_LAT=3 is driven with directed timing checks.
// Monitor pops expected accesses/returns whenever the DUT presents them.
module tb_dmem_arbiter;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // ---- main DUT (MEM_LAT=1, STARVE_MAX=4) ----
  logic        c_cpu_req, c_cpu_we, c_cpu_gnt, c_cpu_rvalid, c_cpu_stall;
  logic [63:0] c_cpu_addr, c_cpu_wdata, c_cpu_rdata;
  logic        c_dbg_req, c_dbg_we, c_dbg_gnt, c_dbg_rvalid;
  logic [63:0] c_dbg_addr, c_dbg_wdata, c_dbg_rdata;
  logic        c_mem_en, c_mem_we;
  logic [63:0] c_mem_addr, c_mem_wdata, c_mem_rdata;

  dmem_arbiter #(.ADDR_W(64), .DATA_W(64), .MEM_LAT(1), .STARVE_MAX(4)) u_dut (
    .clk(clk), .reset(reset),
    .cpu_req(c_cpu_req), .cpu_we(c_cpu_we), .cpu_addr(c_cpu_addr), .cpu_wdata(c_cpu_wdata),
    .cpu_gnt(c_cpu_gnt), .cpu_rvalid(c_cpu_rvalid), .cpu_rdata(c_cpu_rdata), .cpu_stall(c_cpu_stall),
    .dbg_req(c_dbg_req), .dbg_we(c_dbg_we), .dbg_addr(c_dbg_addr), .dbg_wdata(c_dbg_wdata),
    .dbg_gnt(c_dbg_gnt), .dbg_rvalid(c_dbg_rvalid), .dbg_rdata(c_dbg_rdata),
    .mem_en(c_mem_en), .mem_we(c_mem_we), .mem_addr(c_mem_addr), .mem_wdata(c_mem_wdata),
    .mem_rdata(c_mem_rdata)
  );

  // ---- second DUT (MEM_LAT=3) ----
  logic        t_cpu_req, t_cpu_we, t_cpu_gnt, t_cpu_rvalid, t_cpu_stall;
  logic [63:0] t_cpu_addr, t_cpu_wdata, t_cpu_rdata;
  logic        t_dbg_req, t_dbg_we, t_dbg_gnt, t_dbg_rvalid;
  logic [63:0] t_dbg_addr, t_dbg_wdata, t_dbg_rdata;
  logic        t_mem_en, t_mem_we;
  logic [63:0] t_mem_addr, t_mem_wdata, t_mem_rdata;

  dmem_arbiter #(.ADDR_W(64), .DATA_W(64), .MEM_LAT(3), .STARVE_MAX(4)) u_dut3 (
    .clk(clk), .reset(reset),
    .cpu_req(t_cpu_req), .cpu_we(t_cpu_we), .cpu_addr(t_cpu_addr), .cpu_wdata(t_cpu_wdata),
    .cpu_gnt(t_cpu_gnt), .cpu_rvalid(t_cpu_rvalid), .cpu_rdata(t_cpu_rdata), .cpu_stall(t_cpu_stall),
    .dbg_req(t_dbg_req), .dbg_we(t_dbg_we), .dbg_addr(t_dbg_addr), .dbg_wdata(t_dbg_wdata),
    .dbg_gnt(t_dbg_gnt), .dbg_rvalid(t_dbg_rvalid), .dbg_rdata(t_dbg_rdata),
    .mem_en(t_mem_en), .mem_we(t_mem_we), .mem_addr(t_mem_addr), .mem_wdata(t_mem_wdata),
    .mem_rdata(t_mem_rdata)
  );

  // ---- memory models ----
  logic [63:0] memm [logic [63:0]];
  logic [63:0] c_rd;
  assign c_mem_rdata = c_rd;
  always @(posedge clk) begin
    if (c_mem_en) begin
      if (c_mem_we) memm[c_mem_addr] = c_mem_wdata;
      c_rd <= memm.exists(c_mem_addr) ? memm[c_mem_addr] : 64'h0;
    end
  end

  // Three-stage memory: data is address + 0x1000
  logic [63:0] t_p0, t_p1, t_p2;
  assign t_mem_rdata = t_p2;
  always @(posedge clk) begin
    t_p0 <= t_mem_addr + 64'h1000;
    t_p1 <= t_p0;
    t_p2 <= t_p1;
  end

  // ---- scoreboard ----
  typedef struct packed {
    logic        own;
    logic        we;
    logic [63:0] addr;
    logic [63:0] wdata;
  } op_t;

  op_t         exp_ops[$];
  logic [63:0] exp_crd[$];
  logic [63:0] exp_drd[$];
  op_t         mon_op;
  logic [63:0] mon_d;
  int          errors = 0;
  int          checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset) begin
      if (c_mem_en) begin
        if (exp_ops.size() == 0) chk("unexpected_mem_en", c_mem_en, 0);
        else begin
          mon_op = exp_ops.pop_front();
          chk("gnt_owner", {c_dbg_gnt, c_cpu_gnt}, mon_op.own ? 64'd2 : 64'd1);
          chk("mem_we", c_mem_we, mon_op.we);
          chk("mem_addr", c_mem_addr, mon_op.addr);
          chk("mem_wdata", c_mem_wdata, mon_op.wdata);
        end
      end else begin
        if (c_cpu_gnt | c_dbg_gnt) chk("gnt_without_mem_en", c_cpu_gnt | c_dbg_gnt, 0);
        if (c_mem_we) chk("mem_we_outside_issue", c_mem_we, 0);
      end
      if (c_cpu_rvalid) begin
        if (exp_crd.size() == 0) chk("unexpected_cpu_rvalid", c_cpu_rvalid, 0);
        else begin
          mon_d = exp_crd.pop_front();
          chk("cpu_rdata", c_cpu_rdata, mon_d);
        end
      end
      if (c_dbg_rvalid) begin
        if (exp_drd.size() == 0) chk("unexpected_dbg_rvalid", c_dbg_rvalid, 0);
        else begin
          mon_d = exp_drd.pop_front();
          chk("dbg_rdata", c_dbg_rdata, mon_d);
        end
      end
    end
  end

  // ---- stimulus helpers ----
  task automatic wait_gnt(input logic sel_dbg);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      seen = sel_dbg ? c_dbg_gnt : c_cpu_gnt;
    end
    if (!seen) chk(sel_dbg ? "dbg_gnt_timeout" : "cpu_gnt_timeout", seen, 1);
  endtask

  task automatic cpu_access(input logic we, input logic [63:0] a, input logic [63:0] d);
    c_cpu_req = 1'b1; c_cpu_we = we; c_cpu_addr = a; c_cpu_wdata = d;
    wait_gnt(1'b0);
    c_cpu_req = 1'b0;
  endtask

  task automatic dbg_access(input logic we, input logic [63:0] a, input logic [63:0] d);
    c_dbg_req = 1'b1; c_dbg_we = we; c_dbg_addr = a; c_dbg_wdata = d;
    wait_gnt(1'b1);
    c_dbg_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running at %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    memm[64'h10] = 64'hDEAD_BEEF;
    memm[64'h30] = 64'h3333;
    memm[64'h40] = 64'h4444;
    memm[64'h50] = 64'h5050_5050;
    c_cpu_req = 0; c_cpu_we = 0; c_cpu_addr = 0; c_cpu_wdata = 0;
    c_dbg_req = 0; c_dbg_we = 0; c_dbg_addr = 0; c_dbg_wdata = 0;
    t_cpu_req = 0; t_cpu_we = 0; t_cpu_addr = 0; t_cpu_wdata = 0;
    t_dbg_req = 0; t_dbg_we = 0; t_dbg_addr = 0; t_dbg_wdata = 0;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mem_en", c_mem_en, 0);
    chk("rst_gnts", {c_cpu_gnt, c_dbg_gnt}, 0);
    chk("rst_rvalids", {c_cpu_rvalid, c_dbg_rvalid}, 0);
    chk("rst_cpu_rdata", c_cpu_rdata, 0);
    chk("rst_mem_addr", c_mem_addr, 0);
    reset = 1'b1;

    // 1: CPU load, MEM_LAT=1
    @(posedge clk); #1;
    exp_ops.push_back('{1'b0, 1'b0, 64'h10, 64'h0});
    exp_crd.push_back(64'hDEAD_BEEF);
    c_cpu_req = 1; c_cpu_we = 0; c_cpu_addr = 64'h10; c_cpu_wdata = 0;
    @(negedge clk);
    chk("t1_stall_arb", c_cpu_stall, 1);
    chk("t1_no_en_arb", c_mem_en, 0);
    @(negedge clk);
    chk("t1_gnt", c_cpu_gnt, 1);
    chk("t1_stall_issue", c_cpu_stall, 1);
    @(negedge clk);
    chk("t1_stall_wait", c_cpu_stall, 1);
    chk("t1_no_rvalid_wait", c_cpu_rvalid, 0);
    @(negedge clk);
    chk("t1_rvalid", c_cpu_rvalid, 1);
    chk("t1_stall_done", c_cpu_stall, 0);
    c_cpu_req = 0;
    repeat (4) @(negedge clk);

    // 2: CPU store, then read it back
    @(posedge clk); #1;
    exp_ops.push_back('{1'b0, 1'b1, 64'h20, 64'h55});
    c_cpu_req = 1; c_cpu_we = 1; c_cpu_addr = 64'h20; c_cpu_wdata = 64'h55;
    @(negedge clk);
    chk("t2_stall_arb", c_cpu_stall, 1);
    @(negedge clk);
    chk("t2_gnt", c_cpu_gnt, 1);
    chk("t2_stall_gnt", c_cpu_stall, 0);
    c_cpu_req = 0;
    repeat (4) @(negedge clk);
    exp_ops.push_back('{1'b0, 1'b0, 64'h20, 64'h0});
    exp_crd.push_back(64'h55);
    cpu_access(1'b0, 64'h20, 64'h0);
    repeat (4) @(negedge clk);

    // 3: simultaneous requests, CPU first then DBG
    exp_ops.push_back('{1'b0, 1'b0, 64'h30, 64'h0});
    exp_ops.push_back('{1'b1, 1'b0, 64'h40, 64'h0});
    exp_crd.push_back(64'h3333);
    exp_drd.push_back(64'h4444);
    fork
      cpu_access(1'b0, 64'h30, 64'h0);
      dbg_access(1'b0, 64'h40, 64'h0);
    join
    repeat (6) @(negedge clk);

    // 4: both held continuously: C C C C D C C C C D
    for (int i = 0; i < 10; i++) begin
      if (i % 5 == 4) exp_ops.push_back('{1'b1, 1'b1, 64'h60, 64'h77});
      else begin
        exp_ops.push_back('{1'b0, 1'b0, 64'h50, 64'h0});
        exp_crd.push_back(64'h5050_5050);
      end
    end
    @(posedge clk); #1;
    c_cpu_req = 1; c_cpu_we = 0; c_cpu_addr = 64'h50; c_cpu_wdata = 0;
    c_dbg_req = 1; c_dbg_we = 1; c_dbg_addr = 64'h60; c_dbg_wdata = 64'h77;
    n = 0;
    for (int i = 0; i < 100 && n < 10; i++) begin
      @(negedge clk);
      if (c_mem_en) n++;
    end
    c_cpu_req = 0; c_dbg_req = 0;
    chk("t4_issue_count", n, 10);
    repeat (6) @(negedge clk);

    // 5: MEM_LAT=3 DBG read; CPU request during WAIT waits for IDLE
    @(posedge clk); #1;
    t_dbg_req = 1; t_dbg_we = 0; t_dbg_addr = 64'h70;
    @(negedge clk);
    chk("t5_no_en_arb", t_mem_en, 0);
    @(negedge clk);
    chk("t5_dbg_gnt", t_dbg_gnt, 1);
    chk("t5_mem_addr", t_mem_addr, 64'h70);
    t_dbg_req = 0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      if (k == 0) begin
        t_cpu_req = 1; t_cpu_we = 0; t_cpu_addr = 64'h80;
      end
      @(negedge clk);
      chk("t5_wait_no_en", t_mem_en, 0);
      chk("t5_wait_no_cpu_gnt", t_cpu_gnt, 0);
      chk("t5_wait_no_rvalid", t_dbg_rvalid, 0);
    end
    @(negedge clk);
    chk("t5_dbg_rvalid", t_dbg_rvalid, 1);
    chk("t5_dbg_rdata", t_dbg_rdata, 64'h1070);
    chk("t5_no_cpu_gnt_idle", t_cpu_gnt, 0);
    @(negedge clk);
    chk("t5_cpu_gnt", t_cpu_gnt, 1);
    chk("t5_cpu_addr", t_mem_addr, 64'h80);
    t_cpu_req = 0;
    repeat (3) @(negedge clk);
    chk("t5_cpu_no_rvalid_early", t_cpu_rvalid, 0);
    @(negedge clk);
    chk("t5_cpu_rvalid", t_cpu_rvalid, 1);
    chk("t5_cpu_rdata", t_cpu_rdata, 64'h1080);
    repeat (3) @(negedge clk);

    // 6: reset during WAIT of a CPU read
    @(posedge clk); #1;
    exp_ops.push_back('{1'b0, 1'b0, 64'h10, 64'h0});
    c_cpu_req = 1; c_cpu_we = 0; c_cpu_addr = 64'h10; c_cpu_wdata = 0;
    @(negedge clk);
    @(negedge clk);
    chk("t6_gnt", c_cpu_gnt, 1);
    c_cpu_req = 0;
    @(posedge clk); #2;
    reset = 1'b0;
    #1;
    chk("t6_rst_gnts", {c_cpu_gnt, c_dbg_gnt}, 0);
    chk("t6_rst_rvalids", {c_cpu_rvalid, c_dbg_rvalid}, 0);
    chk("t6_rst_mem", {c_mem_en, c_mem_we}, 0);
    chk("t6_rst_cpu_rdata", c_cpu_rdata, 0);
    chk("t6_rst_mem_addr", c_mem_addr, 0);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (6) @(negedge clk);
    exp_ops.push_back('{1'b0, 1'b0, 64'h20, 64'h0});
    exp_crd.push_back(64'h55);
    cpu_access(1'b0, 64'h20, 64'h0);
    repeat (5) @(negedge clk);

    chk("left_ops", exp_ops.size(), 0);
    chk("left_cpu_rd", exp_crd.size(), 0);
    chk("left_dbg_rd", exp_drd.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-master arbiter for the single-port data memory of the RISC-V core.
- Masters: the processor load/store path (CPU port) and a debug/program-loader port (DBG port).
- Serialises accesses and stalls the CPU while it waits.
- CPU has default priority; a starvation counter guarantees DBG forward progress.

Parameters:
- ADDR_W, 64, address width of both masters and the memory.
- DATA_W, 64, data width.
- MEM_LAT, 1, cycles from mem_en to valid mem_rdata; legal range 1..15.
- STARVE_MAX, 4, consecutive lost arbitrations after which DBG wins the next arbitration; legal range 1..15.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous reset, active-low.
- cpu_req  in  1  CPU access request; held with fields stable until cpu_gnt.
- cpu_we  in  1  1=store, 0=load.
- cpu_addr  in  ADDR_W  CPU byte address.
- cpu_wdata  in  DATA_W  CPU store data.
- cpu_gnt  out  1  one-cycle pulse; CPU access issued this cycle.
- cpu_rvalid  out  1  one-cycle pulse; cpu_rdata valid (loads only).
- cpu_rdata  out  DATA_W  load data, held until the next cpu_rvalid.
- cpu_stall  out  1  combinational: cpu_req & ~(cpu_rvalid | (cpu_gnt & cpu_we)).
- dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_gnt, dbg_rvalid, dbg_rdata: same widths and rules as the CPU equivalents.
- mem_en  out  1  memory access strobe, one cycle per access.
- mem_we  out  1  memory write enable, qualified by mem_en.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data, valid MEM_LAT cycles after mem_en.

Behaviour:
- States: IDLE, ISSUE, WAIT.
- IDLE: arbitrates on the current req inputs.
  - DBG wins if dbg_req & (~cpu_req | starve_cnt==STARVE_MAX); otherwise CPU wins if cpu_req.
  - The winner's we/addr/wdata and an owner bit are registered.
  - Next state: ISSUE if any request is pending, else stay in IDLE.
- ISSUE (exactly 1 cycle):
  - mem_en=1; mem_we/addr/wdata driven from the registers.
  - Owner's gnt=1.
  - Goes to WAIT with lat_cnt=MEM_LAT-1.
- WAIT:
  - Decrements lat_cnt each cycle.
  - When lat_cnt==0: if the access was a read, capture mem_rdata into the owner's rdata register and pulse the owner's rvalid in the following cycle (registered). Writes produce no rvalid.
  - Then return to IDLE.
- Timing:
  - Read latency from the arbitration cycle to rvalid = MEM_LAT+2 cycles.
  - Throughput = one access per MEM_LAT+2 cycles.
  - Only one access is outstanding at a time.
- starve_cnt (4-bit):
  - Updated only in IDLE cycles where a grant is made.
  - +1 when DBG requested but CPU won, saturating at STARVE_MAX.
  - Cleared when DBG wins.
  - Unchanged when DBG is not requesting.
- Outside ISSUE, mem_en=0 and mem_we=0; mem_addr/mem_wdata hold their last values.
- Requests deasserted after gnt are ignored. A req still high after its rvalid is treated as a new access.
- A requester dropping req before gnt is legal: the request is discarded if arbitration has not yet happened.
- Reset (asserted at any time, including mid-access):
  - state=IDLE; starve_cnt=0.
  - All gnt, rvalid, mem_en and mem_we forced to 0.
  - Data/address registers cleared to 0.
  - An in-flight access is abandoned and no rvalid is ever produced for it.
- On release, the first arbitration occurs at the first rising edge with reset high.

Test Plan:
- CPU-only load, MEM_LAT=1, mem_rdata=64'hDEAD_BEEF at addr 0x10 -> mem_en one cycle after req; cpu_gnt in the same cycle; cpu_rvalid with cpu_rdata=64'hDEAD_BEEF three cycles after req; cpu_stall high until then.
- CPU store addr 0x20 data 0x55 -> a single mem_en with mem_we=1, addr 0x20, wdata 0x55; cpu_gnt pulses; no cpu_rvalid; cpu_stall drops in the gnt cycle.
- Both request in the same cycle, starve_cnt=0 -> CPU granted first, DBG granted in the next arbitration (CPU idle); starve_cnt returns to 0.
- cpu_req held high continuously and dbg_req high, STARVE_MAX=4 -> CPU wins 4 arbitrations, DBG wins the 5th, then CPU wins again; pattern repeats.
- MEM_LAT=3, DBG read -> exactly 3 WAIT cycles; dbg_rvalid 5 cycles after the arbitration cycle; cpu_req arriving during WAIT is granted only after return to IDLE.
- reset pulled low during WAIT of a CPU read -> all outputs 0 immediately; after release no stale cpu_rvalid; a fresh request completes normally.
